piso_serializer: RTL and testbench

//   Parametrised parallel-in/serial-out shifter with a valid/ready load handshake and a shift-enable input.

---
 rtl/piso_pkg.sv | 8 +
 rtl/piso_bit_counter.sv | 30 +++
 rtl/piso_serializer.sv | 118 +++++++++++
 tb/tb_piso_serializer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and limits for the PISO serializer
package piso_pkg;

    typedef enum logic [1:0] {PISO_IDLE, PISO_SHIFT, PISO_PARITY} piso_state_t;

    localparam int PISO_MIN_WIDTH = 2;

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: counts displayed bits of the current word and flags the last data bit
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       inc,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       is_last
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Clear has priority so a new word always starts counting from bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CW'(1);
    end

    assign is_last = cnt == LAST;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with valid/ready load and shift_en bit pacing.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] d_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_first,
    output logic             frame_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    if (WIDTH < PISO_MIN_WIDTH) begin : g_width_check
        $error("piso_serializer: WIDTH must be at least %0d", PISO_MIN_WIDTH);
    end

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    bit_cnt;
    logic             is_last;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic             cnt_clr;
    logic             cnt_inc;
`ifdef PISO_PARITY_EN
    logic             parity;
`endif

    // Handshake and datapath helpers; ready opens on the strobe that retires the final frame bit so words chain gaplessly
    always_comb begin
        load_ready = rst_n & ((state == PISO_IDLE) | (frame_last & shift_en));
        accept     = load_valid & load_ready;
        shreg_nxt  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        first_bit  = MSB_FIRST ? d_in[WIDTH-1] : d_in[0];
        next_bit   = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
        cnt_inc    = (state == PISO_SHIFT) & shift_en & ~is_last;
        cnt_clr    = accept | ((state == PISO_SHIFT) & shift_en & is_last);
    end

    assign busy = state != PISO_IDLE;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .cnt    (bit_cnt),
        .is_last(is_last)
    );

    // Frame FSM: an accept loads the next word; otherwise each shift_en strobe retires the displayed bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PISO_IDLE;
            shreg        <= '0;
            serial_out   <= IDLE_LEVEL;
            serial_valid <= 1'b0;
            frame_first  <= 1'b0;
            frame_last   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity       <= 1'b0;
`endif
        end else if (accept) begin
            state        <= PISO_SHIFT;
            shreg        <= d_in;
            serial_out   <= first_bit;
            serial_valid <= 1'b1;
            frame_first  <= 1'b1;
            frame_last   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity       <= ^d_in;
`endif
        end else if (shift_en && state == PISO_SHIFT && !is_last) begin
            shreg        <= shreg_nxt;
            serial_out   <= next_bit;
            frame_first  <= 1'b0;
            frame_last   <= !PARITY_EN && (bit_cnt == PENULT);
        end
`ifdef PISO_PARITY_EN
        else if (shift_en && state == PISO_SHIFT) begin
            state        <= PISO_PARITY;
            serial_out   <= parity;
            frame_first  <= 1'b0;
            frame_last   <= 1'b1;
        end
`endif
        else if (shift_en && state != PISO_IDLE) begin
            state        <= PISO_IDLE;
            serial_out   <= IDLE_LEVEL;
            serial_valid <= 1'b0;
            frame_first  <= 1'b0;
            frame_last   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table vectors, corner sequences and random traffic against a queue-based frame model
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
    localparam logic [2*FL-1:0] B2B = 10'b1011101111;
`else
    localparam int FL = W;
    localparam logic [2*FL-1:0] B2B = 8'b10110111;
`endif

    typedef struct {
        logic [3:0] d;
        logic [3:0] m;
        logic [3:0] l;
        logic       p;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] d_in = '0;
    logic         shift_en = 1'b1;
    logic         load_ready_a, serial_out_a, serial_valid_a, frame_first_a, frame_last_a, busy_a;
    logic         load_ready_b, serial_out_b, serial_valid_b, frame_first_b, frame_last_b, busy_b;

    int           n_run = 0;
    int           n_fail = 0;
    bit           qa[$];
    bit           qb[$];
    logic         last_rdy;
    vec_t         tbl[6];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_a),
        .d_in(d_in), .shift_en(shift_en), .serial_out(serial_out_a), .serial_valid(serial_valid_a),
        .frame_first(frame_first_a), .frame_last(frame_last_a), .busy(busy_a)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_b),
        .d_in(d_in), .shift_en(shift_en), .serial_out(serial_out_b), .serial_valid(serial_valid_b),
        .frame_first(frame_first_b), .frame_last(frame_last_b), .busy(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Expected outputs follow from how many bits of the current frame are still pending
    task automatic check_dut(input string nm, input int sz, input bit head, input logic so,
                             input logic sv, input logic ff, input logic fl, input logic bz);
        chk({nm, ".serial_out"}, so, sz > 0 ? head : 1'b1);
        chk({nm, ".serial_valid"}, sv, sz > 0);
        chk({nm, ".frame_first"}, ff, sz == FL);
        chk({nm, ".frame_last"}, fl, sz == 1);
        chk({nm, ".busy"}, bz, sz > 0);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, ".a.serial_out"}, serial_out_a, 1'b1);
        chk({nm, ".a.serial_valid"}, serial_valid_a, 1'b0);
        chk({nm, ".a.frame_first"}, frame_first_a, 1'b0);
        chk({nm, ".a.frame_last"}, frame_last_a, 1'b0);
        chk({nm, ".a.busy"}, busy_a, 1'b0);
        chk({nm, ".a.load_ready"}, load_ready_a, 1'b0);
        chk({nm, ".b.serial_out"}, serial_out_b, 1'b1);
        chk({nm, ".b.load_ready"}, load_ready_b, 1'b0);
    endtask

    // One clock: drive, check ready against the model, clock, update model, check outputs
    task automatic cyc(input logic lv, input logic [W-1:0] d, input logic se);
        bit rdy_m;
        bit acc;
        load_valid = lv;
        d_in = d;
        shift_en = se;
        #1;
        rdy_m = (qa.size() == 0) || (qa.size() == 1 && se);
        last_rdy = load_ready_a;
        chk("a.load_ready", load_ready_a, rdy_m);
        chk("b.load_ready", load_ready_b, rdy_m);
        acc = lv && rdy_m;
        @(posedge clk);
        #1;
        if (se && qa.size() > 0) void'(qa.pop_front());
        if (se && qb.size() > 0) void'(qb.pop_front());
        if (acc) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < W; i++) begin
                qa.push_back(d[W-1-i]);
                qb.push_back(d[i]);
            end
`ifdef PISO_PARITY_EN
            qa.push_back(($countones(d) % 2) == 1);
            qb.push_back(($countones(d) % 2) == 1);
`endif
        end
        check_dut("a", qa.size(), qa.size() > 0 ? qa[0] : 1'b1, serial_out_a, serial_valid_a,
                  frame_first_a, frame_last_a, busy_a);
        check_dut("b", qb.size(), qb.size() > 0 ? qb[0] : 1'b1, serial_out_b, serial_valid_b,
                  frame_first_b, frame_last_b, busy_b);
    endtask

    initial begin
        int   strobes;
        int   pulses;
        logic [2*FL-1:0] got;

        tbl[0] = '{d: 4'hB, m: 4'b1011, l: 4'b1101, p: 1'b1};
        tbl[1] = '{d: 4'h3, m: 4'b0011, l: 4'b1100, p: 1'b0};
        tbl[2] = '{d: 4'h7, m: 4'b0111, l: 4'b1110, p: 1'b1};
        tbl[3] = '{d: 4'h8, m: 4'b1000, l: 4'b0001, p: 1'b1};
        tbl[4] = '{d: 4'h0, m: 4'b0000, l: 4'b0000, p: 1'b0};
        tbl[5] = '{d: 4'hF, m: 4'b1111, l: 4'b1111, p: 1'b0};

        // Reset held across clocks, then released
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        #1;
        chk("release.a.load_ready", load_ready_a, 1'b1);
        chk("release.b.load_ready", load_ready_b, 1'b1);

        // Table vectors with shift_en held high
        foreach (tbl[k]) begin
            cyc(1'b1, tbl[k].d, 1'b1);
            for (int i = 0; i < FL; i++) begin
                chk($sformatf("tbl%0d.a.bit%0d", k, i), serial_out_a, i < W ? tbl[k].m[3-i] : tbl[k].p);
                chk($sformatf("tbl%0d.b.bit%0d", k, i), serial_out_b, i < W ? tbl[k].l[3-i] : tbl[k].p);
                cyc(1'b0, '0, 1'b1);
            end
        end

        // Back-to-back 4'hB then 4'h7 held valid
        cyc(1'b1, 4'hB, 1'b1);
        pulses = 0;
        got = '0;
        for (int i = 0; i < 2 * FL; i++) begin
            got[2*FL-1-i] = serial_out_a;
            chk($sformatf("b2b.valid%0d", i), serial_valid_a, 1'b1);
            cyc(i < FL, 4'h7, 1'b1);
            if (i < FL && last_rdy) pulses++;
        end
        chk("b2b.bits", got, B2B);
        chk("b2b.ready_pulses", pulses, 1);

        // shift_en pattern 0,0,1 stretches every bit; count strobes to frame end
        cyc(1'b1, 4'hB, 1'b1);
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            logic se;
            if (!busy_a) break;
            se = (k % 3) == 2;
            if (se) strobes++;
            cyc(1'b0, '0, se);
        end
        chk("stretch.strobes", strobes, FL);
        chk("stretch.idle", busy_a, 1'b0);

        // Asynchronous reset while the third bit of 4'hB is displayed
        cyc(1'b1, 4'hB, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) cyc(1'b0, '0, 1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++)
            cyc(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) != 0));
        repeat (3 * FL) cyc(1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
